// File: rtl/seq_alu.sv
// Sequential integer ALU: single-cycle logic/shift/compare ops, plus an iterative
// shift-add multiplier and restoring divider that take DATA_WIDTH cycles each.
module seq_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic                  kill_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] ALUresult_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int W   = DATA_WIDTH;
  localparam logic [SHW-1:0] LAST_STEP = SHW'(W - 1);
  localparam logic [W-1:0]   MOST_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB   = 5'd1,  OP_SLL    = 5'd2,  OP_SLT   = 5'd3,
    OP_SLTU = 5'd4,  OP_XOR   = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7,
    OP_OR   = 5'd8,  OP_AND   = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11,
    OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14, OP_DIVU  = 5'd15,
    OP_REM  = 5'd16, OP_REMU  = 5'd17
  } op_e;

  state_e         state_q;
  op_e            op_q;
  logic [SHW-1:0] cnt_q;
  logic [W-1:0]   work_hi_q;   // product high half / partial remainder
  logic [W-1:0]   work_lo_q;   // multiplier bits / quotient bits
  logic [W-1:0]   mcand_q;     // multiplicand / divisor magnitude
  logic           neg_q;       // product or quotient needs negation
  logic           rem_neg_q;   // remainder takes the dividend's sign
  logic [W-1:0]   result_q;
  logic           valid_q;

  // Request decode and single-cycle results
  op_e            op_dec;
  logic [SHW-1:0] sh_amt;
  logic [W-1:0]   short_res;
  logic           is_mul, is_div, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag, special_res;

  // NOTE: every combinational output gets a default at the top of the block so
  // no path through the case statements can leave it unassigned (no latches).
  always_comb begin
    op_dec    = (op_i > 5'd17) ? OP_ADD : op_e'(op_i);
    sh_amt    = srcB_i[SHW-1:0];
    short_res = '0;
    case (op_dec)
      OP_ADD:  short_res = srcA_i + srcB_i;
      OP_SUB:  short_res = srcA_i - srcB_i;
      OP_SLL:  short_res = srcA_i << sh_amt;
      OP_SLT:  short_res = {{(W-1){1'b0}}, $signed(srcA_i) < $signed(srcB_i)};
      OP_SLTU: short_res = {{(W-1){1'b0}}, srcA_i < srcB_i};
      OP_XOR:  short_res = srcA_i ^ srcB_i;
      OP_SRL:  short_res = srcA_i >> sh_amt;
      OP_SRA:  short_res = $unsigned($signed(srcA_i) >>> sh_amt);
      OP_OR:   short_res = srcA_i | srcB_i;
      OP_AND:  short_res = srcA_i & srcB_i;
      default: short_res = '0;
    endcase

    is_mul   = op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div   = op_dec inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_neg    = (op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && srcA_i[W-1];
    b_neg    = (op_dec inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && srcB_i[W-1];
    a_mag    = a_neg ? -srcA_i : srcA_i;
    b_mag    = b_neg ? -srcB_i : srcB_i;
    div_zero = (srcB_i == '0);
    div_ovf  = (op_dec inside {OP_DIV, OP_REM}) && (srcA_i == MOST_NEG) && (srcB_i == '1);

    if (op_dec inside {OP_DIV, OP_DIVU}) special_res = div_zero ? '1 : MOST_NEG;
    else                                 special_res = div_zero ? srcA_i : '0;
  end

  // One iteration step, plus the sign-corrected result once the last step lands
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [W-1:0]   step_hi_d, step_lo_d, quot_d, rem_d, final_res_d;
  logic [2*W-1:0] prod_d;

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? mcand_q : '0)};
    div_shift = {work_hi_q, work_lo_q[W-1]};
    div_diff  = div_shift - {1'b0, mcand_q};

    if (op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) begin
      step_hi_d = mul_sum[W:1];
      step_lo_d = {mul_sum[0], work_lo_q[W-1:1]};
    end else if (!div_diff[W]) begin
      step_hi_d = div_diff[W-1:0];
      step_lo_d = {work_lo_q[W-2:0], 1'b1};
    end else begin
      step_hi_d = div_shift[W-1:0];
      step_lo_d = {work_lo_q[W-2:0], 1'b0};
    end

    prod_d = {step_hi_d, step_lo_d};
    if (neg_q) prod_d = -prod_d;
    quot_d = neg_q     ? -step_lo_d : step_lo_d;
    rem_d  = rem_neg_q ? -step_hi_d : step_hi_d;

    case (op_q)
      OP_MUL:                        final_res_d = prod_d[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res_d = prod_d[2*W-1:W];
      OP_DIV, OP_DIVU:               final_res_d = quot_d;
      OP_REM, OP_REMU:               final_res_d = rem_d;
      default:                       final_res_d = '0;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (kill_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              op_q  <= op_dec;
              cnt_q <= '0;
              if (is_mul) begin
                state_q   <= BUSY;
                work_hi_q <= '0;
                work_lo_q <= b_mag;
                mcand_q   <= a_mag;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= 1'b0;
              end else if (is_div && !div_zero && !div_ovf) begin
                state_q   <= BUSY;
                work_hi_q <= '0;
                work_lo_q <= a_mag;
                mcand_q   <= b_mag;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
              end else begin
                state_q  <= DONE;
                result_q <= is_div ? special_res : short_res;
                valid_q  <= 1'b1;
              end
            end
          end
          BUSY: begin
            work_hi_q <= step_hi_d;
            work_lo_q <= step_lo_d;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              state_q  <= DONE;
              result_q <= final_res_d;
              valid_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A kill landing in the DONE cycle withdraws the pulse that cycle
  assign valid_o     = valid_q & ~kill_i;
  assign ready_o     = (state_q == IDLE) & ~rst_i;
  assign ALUresult_o = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (DATA_WIDTH=32): directed corner cases, kill and
// reset scenarios, then randomized ops scored against a plain-arithmetic model.
module tb_seq_alu;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk_i = 1'b0;
  logic         rst_i, valid_i, kill_i;
  logic         ready_o, valid_o;
  logic [4:0]   op_i;
  logic [W-1:0] srcA_i, srcB_i, ALUresult_o;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .srcA_i      (srcA_i),
    .srcB_i      (srcB_i),
    .kill_i      (kill_i),
    .valid_o     (valid_o),
    .ALUresult_o (ALUresult_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each opcode
  function automatic logic [W-1:0] model(input int op_in, input logic [W-1:0] a, input logic [W-1:0] b);
    int                op;
    longint            sa, sb, ubs, p;
    longint unsigned   ua, ub, pu;
    logic [4:0]        sh;
    op  = (op_in > 17) ? 0 : op_in;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ubs = longint'({32'h0, b});
    sh  = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  begin p = sa >>> sh; return p[31:0]; end
      8:  return a | b;
      9:  return a & b;
      10: begin p = sa * sb;  return p[31:0];  end
      11: begin p = sa * sb;  return p[63:32]; end
      12: begin p = sa * ubs; return p[63:32]; end
      13: begin pu = ua * ub; return pu[63:32]; end
      14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        p = sa / sb; return p[31:0];
      end
      15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      16: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op >= 10 && op <= 13) return W + 1;
    if (op >= 14 && op <= 17) begin
      if (b == 0) return 1;
      if ((op == 14 || op == 16) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
      return W + 1;
    end
    return 1;
  endfunction

  // Issue one op, optionally spraying ignored requests while busy, and score it
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise);
    logic [W-1:0] exp;
    int           exp_lat, lat;
    bit           busy_ready;
    exp     = model(int'(op), a, b);
    exp_lat = model_latency(int'(op), a, b);
    check($sformatf("op%0d_ready_before", op), ready_o, 1);
    op_i = op; srcA_i = a; srcB_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i    = 1'b0;
    lat        = 1;
    busy_ready = 1'b0;
    while (!valid_o && lat < 100) begin
      if (ready_o) busy_ready = 1'b1;
      if (noise) begin
        valid_i = 1'($urandom_range(0, 1));
        op_i    = 5'($urandom);
        srcA_i  = $urandom;
        srcB_i  = $urandom;
      end
      @(posedge clk_i); #1;
      lat++;
    end
    valid_i = 1'b0;
    check($sformatf("op%0d_latency a=%0h b=%0h", op, a, b), lat, exp_lat);
    check($sformatf("op%0d_result a=%0h b=%0h", op, a, b), ALUresult_o, exp);
    if (exp_lat > 1) check($sformatf("op%0d_ready_while_busy", op), busy_ready, 0);
    @(posedge clk_i); #1;
    check($sformatf("op%0d_single_pulse", op), valid_o, 0);
    check($sformatf("op%0d_ready_after", op), ready_o, 1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN_NEG;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] held;
    rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
    op_i = 5'd0; srcA_i = '0; srcB_i = '0;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ready_low", ready_o, 0);
    check("reset_valid_low", valid_o, 0);
    check("reset_result_zero", ALUresult_o, 0);
    rst_i = 1'b0;
    #1;
    check("post_reset_ready", ready_o, 1);

    // Directed corner cases
    run_op(5'd7,  MIN_NEG, 32'h0000_0024, 1'b0);
    check("sra_value", ALUresult_o, 32'hF800_0000);
    run_op(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulh_value", ALUresult_o, 32'h0000_0000);
    run_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhu_value", ALUresult_o, 32'hFFFF_FFFE);
    run_op(5'd14, -32'sd7, 32'd2, 1'b0);
    check("div_neg_value", ALUresult_o, 32'hFFFF_FFFD);
    run_op(5'd16, -32'sd7, 32'd2, 1'b0);
    check("rem_neg_value", ALUresult_o, 32'hFFFF_FFFF);
    run_op(5'd15, 32'd1234, 32'd0, 1'b0);
    check("divu_zero_value", ALUresult_o, 32'hFFFF_FFFF);
    run_op(5'd17, 32'd1234, 32'd0, 1'b0);
    run_op(5'd14, MIN_NEG, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_value", ALUresult_o, MIN_NEG);
    run_op(5'd16, MIN_NEG, 32'hFFFF_FFFF, 1'b0);
    check("rem_ovf_value", ALUresult_o, 32'd0);
    run_op(5'd25, 32'd40, 32'd2, 1'b0);
    run_op(5'd0, 32'd100, 32'd23, 1'b0);

    // Request arriving together with kill in IDLE is dropped
    held = ALUresult_o;
    op_i = 5'd0; srcA_i = 32'd1; srcB_i = 32'd1; valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    check("idle_kill_no_valid", valid_o, 0);
    check("idle_kill_ready", ready_o, 1);
    watch_no_valid("idle_kill_no_late_pulse", 3);
    check("idle_kill_result_held", ALUresult_o, held);

    // Kill in BUSY cycle 10 of a divide
    op_i = 5'd14; srcA_i = 32'd100; srcB_i = 32'd3; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    check("kill_still_busy", ready_o, 0);
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill_ready_next", ready_o, 1);
    check("kill_no_valid", valid_o, 0);
    check("kill_result_held", ALUresult_o, held);
    watch_no_valid("kill_no_late_pulse", 40);
    run_op(5'd0, 32'd5, 32'd7, 1'b0);
    check("add_after_kill", ALUresult_o, 32'd12);

    // Randomized ops, with ignored requests sprayed while busy
    for (int i = 0; i < 300; i++) begin
      run_op(5'($urandom_range(0, 31)), pick_operand(), pick_operand(), 1'b1);
    end

    // Reset in BUSY cycle 20 of a multiply
    run_op(5'd0, 32'd5, 32'd7, 1'b0);
    op_i = 5'd10; srcA_i = 32'h1234_5678; srcB_i = 32'h9ABC_DEF0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1;
    check("mul_busy_before_reset", ready_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("midbusy_reset_result", ALUresult_o, 0);
    check("midbusy_reset_valid", valid_o, 0);
    check("midbusy_reset_ready", ready_o, 0);
    rst_i = 1'b0;
    #1;
    check("midbusy_release_ready", ready_o, 1);
    watch_no_valid("midbusy_no_pulse", 40);
    check("midbusy_idle_after", ready_o, 1);
    check("midbusy_result_still_zero", ALUresult_o, 0);
    run_op(5'd1, 32'd10, 32'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
